// File: rtl/mcl_req_arbiter_pkg.sv
// Shared helpers for the MCL request arbiter slice.
package mcl_req_arbiter_pkg;

  // Index width for a set of n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small ready/valid FIFO with a combinational head read, used for in-order response tags.
module bsg_fifo_1r1w_small
  import mcl_req_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = id_width(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr_q;
  logic [ptr_w-1:0]   rd_ptr_q;
  logic [cnt_w-1:0]   count_q;
  logic               push;
  logic               pop;

  assign ready_o = (count_q != cnt_w'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem[rd_ptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push & ~pop)      count_q <= count_q + 1'b1;
      else if (pop & ~push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/mcl_req_arbiter_rr_arb.sv
// Round-robin arbiter: grants the first eligible requester after the last winner.
module mcl_rr_arb
  import mcl_req_arbiter_pkg::*;
#(
  parameter int num_p = 2,
  localparam int id_w = id_width(num_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [num_p-1:0] v_i,
  input  logic             yumi_i,
  output logic [num_p-1:0] grant_o,
  output logic [id_w-1:0]  id_o
);

  logic [id_w-1:0] last_q;
  logic [id_w:0]   cand;
  logic            found;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= num_p; k++) begin
      cand = {1'b0, last_q} + (id_w + 1)'(k);
      if (cand >= (id_w + 1)'(num_p)) cand = cand - (id_w + 1)'(num_p);
      if (!found && v_i[cand[id_w-1:0]]) begin
        found                     = 1'b1;
        grant_o[cand[id_w-1:0]]   = 1'b1;
        id_o                      = cand[id_w-1:0];
      end
    end
  end

  // Reset to the last index so requester 0 wins the first contest.
  always_ff @(posedge clk_i) begin
    if (reset_i)     last_q <= id_w'(num_p - 1);
    else if (yumi_i) last_q <= id_o;
  end

endmodule

// File: rtl/mcl_req_arbiter.sv
// Shares the outbound MCL link among requesters and routes responses back via an in-order tag FIFO.
module mcl_req_arbiter
  import mcl_req_arbiter_pkg::*;
#(
  parameter int mcl_width_p = 128,
  parameter int num_req_p   = 2,
  parameter int max_out_p   = 8,
  parameter int tag_els_p   = num_req_p * max_out_p
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*mcl_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]             req_expect_resp_i,
  output logic [num_req_p-1:0]             req_r_o,
  output logic [num_req_p-1:0]             resp_v_o,
  output logic [mcl_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]             resp_r_i,
  output logic                             mcl_v_o,
  output logic [mcl_width_p-1:0]           mcl_data_o,
  input  logic                             mcl_r_i,
  input  logic                             mcl_v_i,
  input  logic [mcl_width_p-1:0]           mcl_data_i,
  output logic                             mcl_r_o,
  output logic                             error_o
);

  localparam int id_w  = id_width(num_req_p);
  localparam int cnt_w = $clog2(max_out_p + 1);

  logic                   out_v_q;
  logic [mcl_width_p-1:0] out_data_q;
  logic                   error_q;
  logic                   load_ok;
  logic [num_req_p-1:0]   eligible;
  logic [num_req_p-1:0]   grant;
  logic [id_w-1:0]        grant_id;
  logic                   accept;
  logic                   tag_push;
  logic                   tag_pop;
  logic                   tag_ready;
  logic                   tag_v;
  logic [id_w-1:0]        tag_head;
  logic                   matched;
  logic                   resp_hs;
  logic                   unmatched;

  assign load_ok = ~out_v_q | mcl_r_i;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : gen_req
      logic [cnt_w-1:0] cnt_q;
      logic             inc;
      logic             dec;

      assign inc = tag_push & (grant_id == id_w'(gi));
      assign dec = tag_pop & (tag_head == id_w'(gi));

      // Response-expecting requests also need a free credit and FIFO space.
      assign eligible[gi] = ~reset_i & req_v_i[gi] & load_ok &
                            (~req_expect_resp_i[gi] |
                             ((cnt_q < cnt_w'(max_out_p)) & tag_ready));

      assign resp_v_o[gi] = matched & mcl_v_i & (tag_head == id_w'(gi));

      always_ff @(posedge clk_i) begin
        if (reset_i)          cnt_q <= '0;
        else if (inc & ~dec)  cnt_q <= cnt_q + 1'b1;
        else if (dec & ~inc)  cnt_q <= cnt_q - 1'b1;
      end
    end
  endgenerate

  mcl_rr_arb #(.num_p(num_req_p)) arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (eligible),
    .yumi_i  (accept),
    .grant_o (grant),
    .id_o    (grant_id)
  );

  assign accept   = |grant;
  assign req_r_o  = grant;
  assign tag_push = accept & req_expect_resp_i[grant_id];

  bsg_fifo_1r1w_small #(.width_p(id_w), .els_p(tag_els_p)) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (tag_push),
    .ready_o (tag_ready),
    .data_i  (grant_id),
    .v_o     (tag_v),
    .data_o  (tag_head),
    .yumi_i  (tag_pop)
  );

  // Responses with no outstanding tag are swallowed and flagged.
  assign matched     = tag_v & ~reset_i;
  assign resp_hs     = matched & mcl_v_i & resp_r_i[tag_head];
  assign tag_pop     = resp_hs;
  assign unmatched   = ~reset_i & ~tag_v & mcl_v_i;
  assign mcl_r_o     = ~reset_i & (tag_v ? resp_r_i[tag_head] : 1'b1);
  assign resp_data_o = mcl_data_i;

  assign mcl_v_o    = out_v_q & ~reset_i;
  assign mcl_data_o = out_data_q;
  assign error_o    = error_q & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      out_v_q <= accept | (out_v_q & ~mcl_r_i);
      if (unmatched) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) out_data_q <= req_data_i[grant_id*mcl_width_p +: mcl_width_p];
  end

endmodule

// File: doc/mcl_req_arbiter.md
# mcl_req_arbiter

Shares the single outbound MCL request link (the 128-bit-converted stream leaving the host adapter toward cl_bsg) among `num_req_p` requesters, e.g. host AXI-Lite path and a DMA engine.
- Outbound: round-robin arbitration with a registered output stage.
- Inbound: returns each MCL response to the requester that issued the matching request, using an in-order tag FIFO.
- Enforces a per-requester outstanding-response limit.

## Interface
Parameters:
- `mcl_width_p`, "inv", MCL packet width (one packet = one beat)
- `num_req_p`, 2, number of requesters (>=2)
- `max_out_p`, 8, max outstanding response-expecting requests per requester
- `tag_els_p`, `num_req_p*max_out_p`, tag FIFO depth

Ports (one clock; reset is synchronous, active-high):
- `clk_i` in 1: clock
- `reset_i` in 1: synchronous active-high reset
- `req_v_i` in `num_req_p`: request valid, per requester
- `req_data_i` in `num_req_p*mcl_width_p`: request packets; requester i occupies slice i
- `req_expect_resp_i` in `num_req_p`: request will produce exactly one MCL response
- `req_r_o` out `num_req_p`: request accepted this cycle (handshake = v & r)
- `resp_v_o` out `num_req_p`: response valid, at most one bit set
- `resp_data_o` out `mcl_width_p`: response packet, shared by all requesters
- `resp_r_i` in `num_req_p`: requester ready for response
- `mcl_v_o` out 1, `mcl_data_o` out `mcl_width_p`, `mcl_r_i` in 1: outbound link
- `mcl_v_i` in 1, `mcl_data_i` in `mcl_width_p`, `mcl_r_o` out 1: inbound link
- `error_o` out 1: sticky; set by an unmatched response

## Operation
Eligibility of requester i (all three must hold):
- `req_v_i[i]` is high.
- If `req_expect_resp_i[i]` is high: `out_cnt[i] < max_out_p` and the tag FIFO is not full.
- The output register can load: it is empty, or `mcl_r_i` is draining it this cycle.

Arbitration:
- Round-robin over eligible requesters, searching from `last_q+1` modulo `num_req_p`.
- `req_r_o` is one-hot or zero. It goes only to the winner and is combinational from the inputs.
- `last_q` updates only on an accepted request.

On acceptance of requester i:
- The packet loads into the output register.
- If it expects a response: push i into the tag FIFO and increment `out_cnt[i]`.

Output register:
- `mcl_v_o` and `mcl_data_o` hold stable until `mcl_r_i` is high.
- A drain and a new load can happen in the same cycle, so throughput is 1 packet/cycle.

Responses, when the tag FIFO is non-empty with head `d`:
- `resp_v_o[d] = mcl_v_i`, `resp_data_o = mcl_data_i`, `mcl_r_o = resp_r_i[d]`.
- On handshake: pop the FIFO and decrement `out_cnt[d]`.

Unmatched response (`mcl_v_i` high while the tag FIFO is empty):
- `mcl_r_o = 1`, so the packet is dropped.
- `error_o` is set and stays set until reset.
- All `resp_v_o` stay 0.

Counter rules:
- Increment and decrement of the same `out_cnt[i]` in one cycle: value unchanged.
- Counter width is `$clog2(max_out_p+1)`.
- A counter never wraps. Eligibility gating prevents overflow; the FIFO-empty rule prevents underflow.

Requests with `req_expect_resp_i = 0` do not touch the tag FIFO or the counters.

## Timing
Reset values, and behaviour on reset:
- Reset clears the output register valid, the tag FIFO, all `out_cnt`, `error_o` and `last_q` (`last_q` resets to `num_req_p-1`, so requester 0 has first priority).
- A reset in the middle of traffic discards in-flight state. Responses arriving after reset count as unmatched.
- Outputs during reset: `mcl_v_o = 0`, `req_r_o = 0`, `resp_v_o = 0`, `mcl_r_o = 0`, `error_o = 0`.

Latency:
- Request accepted at cycle t: `mcl_v_o` is high at t+1.
- Response path is combinational, 0 cycles.

Combinational paths:
- `req_r_o` may depend combinationally on `mcl_r_i`.
- `mcl_r_o` depends combinationally on `resp_r_i`.
- No combinational path exists from `mcl_v_i` to `req_r_o`.

A response whose handshake happens in the same cycle as an accept that fills the last credit is legal. Counter and FIFO updates occur on the same clock edge.

## Structure
- No new shared-package typedefs. The requester id width `$clog2(num_req_p)` is a local parameter.
- Sub-module `mcl_rr_arb`: round-robin arbiter.
  - Inputs: eligible vector, advance strobe.
  - Outputs: one-hot grant, grant id.
  - Holds the `last_q` register.
- Tag FIFO: the existing `bsg_fifo_1r1w_small`, width = id width, depth `tag_els_p`.

## Test plan
- **Fairness:** both requesters continuously valid with `expect = 0`, `mcl_r_i = 1` → `mcl_data_o` alternates r0,r1,r0,… from cycle 1; one packet per cycle.
- **Backpressure:** `mcl_r_i = 0` for 5 cycles while r1 sends `0xA5` → `mcl_data_o = 0xA5` held stable for 5 cycles; no further `req_r_o`; drained on the first ready cycle.
- **Credit limit:** `max_out_p = 2`, r0 sends 3 expecting requests with no responses → third `req_r_o[0]` stays 0 and r1 is still served. Return one response → third request accepted the next cycle.
- **Response routing:** issue r1, r0, r1 (all expecting), then return responses X, Y, Z → `resp_v_o` order is 2'b10, 2'b01, 2'b10 with data X, Y, Z. Hold `resp_r_i[1] = 0` → `mcl_r_o = 0` until it rises.
- **Unmatched response:** `mcl_v_i = 1` with nothing outstanding → `mcl_r_o = 1`, `resp_v_o = 0`, `error_o = 1` from the next cycle and held.
- **Reset mid-traffic:** assert `reset_i` with 3 outstanding requests → the cycle after reset all counters are 0 and `mcl_v_o = 0`; a later response sets `error_o`.
